// File: rtl/srff_pkg.sv
// srff_pkg: shared FSM state type, default sizes and SR excitation function for the SR driver.
package srff_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int ERR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_e;

    // Returns {s, r}; the don't-care entries resolve to 0 so S=R=1 is unreachable.
    function automatic logic [1:0] sr_excite(input logic cur_bit, input logic tgt_bit);
        return {~cur_bit & tgt_bit, cur_bit & ~tgt_bit};
    endfunction

endpackage

// File: rtl/sr_exc_lane.sv
// sr_exc_lane: combinational S/R excitation for one flip-flop lane.
module sr_exc_lane
    import srff_pkg::*;
(
    input  logic cur_i,
    input  logic tgt_i,
    output logic s_o,
    output logic r_o
);

    assign {s_o, r_o} = sr_excite(cur_i, tgt_i);

endmodule

// File: rtl/srff_exc_driver.sv
// srff_exc_driver: drives S/R excitation toward a target word and reads back the bank's Q.
// Build option: define SRFF_DRV_CHECK_EN to compare q_fb and enable err/err_cnt.
module srff_exc_driver
    import srff_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tgt_valid_i,
    output logic             tgt_ready_o,
    input  logic [WIDTH-1:0] tgt_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] r_o,
    input  logic [WIDTH-1:0] q_fb_i,
    output logic             done_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    state_e           state_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] r_d;
    logic             accept;

    assign accept = tgt_valid_i & ready_q;

    for (genvar g = 0; g < WIDTH; g++) begin : lane_g
        sr_exc_lane u_lane (
            .cur_i (cur_q[g]),
            .tgt_i (tgt_i[g]),
            .s_o   (s_d[g]),
            .r_o   (r_d[g])
        );
    end

`ifdef SRFF_DRV_CHECK_EN
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             mismatch;

    assign mismatch = (q_fb_i != tgt_q);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= (state_q == CHECK) && mismatch;
            if (state_q == CHECK && mismatch && err_cnt_q != {ERR_W{1'b1}})
                err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb_i;
    assign err_o       = 1'b0;
    assign err_cnt_o   = '0;
`endif

    // Ready is registered so it stays low for the whole reset and the first cycle after it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= ~accept;
                    if (accept) begin
                        tgt_q   <= tgt_i;
                        s_q     <= s_d;
                        r_q     <= r_d;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    s_q     <= '0;
                    r_q     <= '0;
                    cur_q   <= tgt_q;
                    state_q <= CHECK;
                end
                CHECK: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tgt_ready_o = ready_q;
    assign done_o      = done_q;
    assign s_o         = s_q;
    assign r_o         = r_q;

endmodule

// File: tb/tb_srff_exc_driver.sv
// tb_srff_exc_driver: randomized self-checking bench with an SR bank model and transaction-level reference.
module tb_srff_exc_driver;

`ifdef SRFF_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt = 4'b0;
    logic [3:0] s_o;
    logic [3:0] r_o;
    logic [3:0] q_fb;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    logic [3:0] bank;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] cur_m = 4'b0;
    int         errs_m = 0;

    always #5 clk = ~clk;

    srff_exc_driver dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tgt_valid_i (tgt_valid),
        .tgt_ready_o (tgt_ready),
        .tgt_i       (tgt),
        .s_o         (s_o),
        .r_o         (r_o),
        .q_fb_i      (q_fb),
        .done_o      (done),
        .err_o       (err),
        .err_cnt_o   (err_cnt)
    );

    // Behavioural SR flip-flop bank, reset alongside the driver.
    always @(posedge clk) bank <= !rst ? 4'b0 : ((bank & ~r_o) | s_o);
    assign q_fb = force_en ? force_val : bank;

    task automatic test_reset();
        rst = 1'b0;
        tgt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_o !== 4'b0 || r_o !== 4'b0) begin errors++; $display("FAIL reset_sr s=%b r=%b exp 0000/0000", s_o, r_o); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", tgt_ready); end
        rst = 1'b1;
        cur_m = 4'b0;
        errs_m = 0;
        @(posedge clk);
        #1;
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", tgt_ready); end
    endtask

    task automatic txn(input logic [3:0] t, input bit frc, input logic [3:0] fv, input string nm);
        logic [3:0] es, er, qv;
        bit ee;
        int n;
        n = 0;
        while (tgt_ready !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL %s ready_wait got %b exp 1", nm, tgt_ready); end
        es = t & ~cur_m;
        er = cur_m & ~t;
        tgt_valid = 1'b1;
        tgt = t;
        force_en = frc;
        force_val = fv;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        tgt = 4'($urandom);
        checks++; if (s_o !== es || r_o !== er) begin errors++; $display("FAIL %s drive s=%b r=%b exp %b/%b", nm, s_o, r_o, es, er); end
        checks++; if (tgt_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s drive ready=%b done=%b exp 0/0", nm, tgt_ready, done); end
        @(posedge clk);
        #1;
        checks++; if (s_o !== 4'b0 || r_o !== 4'b0 || done !== 1'b0) begin errors++; $display("FAIL %s check_cycle s=%b r=%b done=%b exp 0", nm, s_o, r_o, done); end
        @(posedge clk);
        #1;
        qv = frc ? fv : t;
        ee = CHK && (qv != t);
        if (ee && errs_m < 255) errs_m++;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done got %b exp 1", nm, done); end
        checks++; if (err !== ee) begin errors++; $display("FAIL %s err got %b exp %b", nm, err, ee); end
        checks++; if (err_cnt !== 8'(errs_m)) begin errors++; $display("FAIL %s err_cnt got %0d exp %0d", nm, err_cnt, errs_m); end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after got %b exp 1", nm, tgt_ready); end
        cur_m = t;
        force_en = 1'b0;
    endtask

    task automatic test_directed();
        txn(4'b1010, 1'b0, 4'b0, "set_1010");
        txn(4'b0110, 1'b0, 4'b0, "mix_0110");
    endtask

    task automatic test_error();
        txn(4'b0001, 1'b1, 4'b0000, "forced_err");
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            logic [3:0] t;
            bit f;
            t = 4'($urandom);
            f = ($urandom_range(0, 3) == 0);
            txn(t, f, 4'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        int acc, dn;
        bit have;
        logic [3:0] es, er;
        acc = 0;
        dn = 0;
        tgt_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tgt = 4'($urandom);
            have = (tgt_ready === 1'b1);
            if (have) begin
                acc++;
                es = tgt & ~cur_m;
                er = cur_m & ~tgt;
                cur_m = tgt;
            end
            @(posedge clk);
            #1;
            checks++; if ((s_o & r_o) !== 4'b0) begin errors++; $display("FAIL b2b_s_and_r s=%b r=%b", s_o, r_o); end
            if (have) begin
                checks++; if (s_o !== es || r_o !== er) begin errors++; $display("FAIL b2b_drive s=%b r=%b exp %b/%b", s_o, r_o, es, er); end
            end
            if (done === 1'b1) dn++;
        end
        tgt_valid = 1'b0;
        checks++; if (acc != 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", acc); end
        checks++; if (dn != 3) begin errors++; $display("FAIL b2b_dones got %0d exp 3", dn); end
    endtask

    task automatic test_reset_mid_drive();
        int n;
        n = 0;
        while (tgt_ready !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        tgt_valid = 1'b1;
        tgt = ~cur_m;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (s_o !== 4'b0 || r_o !== 4'b0) begin errors++; $display("FAIL mid_rst_sr s=%b r=%b exp 0000/0000", s_o, r_o); end
        checks++; if (done !== 1'b0 || tgt_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl done=%b ready=%b exp 0/0", done, tgt_ready); end
        rst = 1'b1;
        cur_m = 4'b0;
        errs_m = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_no_done cycle %0d got %b exp 0", k, done); end
        end
        txn(4'b1111, 1'b0, 4'b0, "post_rst_1111");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_error();
        test_random();
        test_back_to_back();
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srff_exc_driver.md
# srff_exc_driver

Excitation driver for a bank of SR flip-flops. It accepts target state words over a valid/ready handshake and keeps a model of the bank's current state. From the two it derives per-lane S/R excitation using the SR excitation table, never driving S=R=1. It then reads back the bank's Q to confirm the transition. It sits in front of the `srff` bank as the stimulus-side counterpart of the flip-flop.

## Interface
- `WIDTH`, 4, number of flip-flop lanes.
- `ERR_W`, 8, width of the saturating mismatch counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `tgt_valid`  in  1  target word offered.
- `tgt_ready`  out  1  driver can accept a target; high only in IDLE.
- `tgt`  in  WIDTH  requested next Q per lane.
- `s`  out  WIDTH  set excitation to the FF bank; registered.
- `r`  out  WIDTH  reset excitation to the FF bank; registered.
- `q_fb`  in  WIDTH  Q outputs of the FF bank.
- `done`  out  1  one-cycle pulse: the transaction completed.
- `err`  out  1  one-cycle pulse, coincident with `done`: `q_fb` ≠ target.
- `err_cnt`  out  ERR_W  saturating count of `err` pulses.

## Operation
- Model register `cur[WIDTH]` holds the expected bank state; reset value 0.
  - The FF bank is reset in the same cycle.
- Per-lane excitation from (`cur`,`tgt`):
  - 0→0: S=0, R=0.
  - 0→1: S=1, R=0.
  - 1→0: S=0, R=1.
  - 1→1: S=0, R=0.
  - Don't-cares resolve to 0, so S=R=1 can never be driven.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: `tgt_ready`=1, `s`=`r`=0. On `tgt_valid`: latch `tgt` into `tgt_q`, load the excitation into `s`/`r`, go to DRIVE.
  - DRIVE: hold `s`/`r` for exactly one cycle, then clear both to 0, set `cur`←`tgt_q`, go to CHECK.
  - CHECK: compare `q_fb` with `tgt_q`, register `done`=1 and `err`=(mismatch), go to IDLE.
    - On mismatch, `err_cnt` increments.
    - `err_cnt` saturates at 2^ERR_W−1 and never wraps.
- `cur` follows the target, not `q_fb`. A mismatch does not resync the model.
- Reset reaches every output: `s`=0, `r`=0, `tgt_ready`=0 during reset, `done`=0, `err`=0, `err_cnt`=0, `cur`=0, state IDLE.
- Reset mid-DRIVE or mid-CHECK: the transaction is abandoned and no `done` is issued.
- `tgt_valid` while not ready is ignored; `tgt` is sampled only on the accept edge.

## Timing
- Edge E0, accept (`tgt_valid`&&`tgt_ready`): `s`/`r` valid in the cycle after E0.
- Edge E1: the FF bank captures; `s`/`r` return to 0.
- Edge E2: `q_fb` is sampled; `done`/`err` are high in the cycle after E2.
- `tgt_ready` is high again in the cycle after E2, so a new accept can coincide with the `done` cycle.
- Throughput: one target per 3 cycles. Latency from accept to `done` is 3 cycles.
- `err_cnt` updates in the same cycle `err` is high.

## Configuration
- `SRFF_DRV_CHECK_EN` defined: CHECK compares `q_fb`; `err` and `err_cnt` are live.
- `SRFF_DRV_CHECK_EN` undefined:
  - `q_fb` is unused.
  - `err` is tied to 0 and `err_cnt` is tied to 0.
  - CHECK remains as a single idle cycle, so latency and `done` timing are identical in both builds.

## Structure
- Shared package `srff_pkg`:
  - FSM state enum (IDLE/DRIVE/CHECK).
  - Function `sr_excite(cur_bit, tgt_bit)` returning a {s,r} pair.
  - Default `WIDTH`/`ERR_W` constants.
- One natural sub-module, `sr_exc_lane`: the combinational per-lane excitation, instantiated WIDTH times. The FSM, model register and counter stay in the top.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `s`=`r`=0, `err_cnt`=0, `done`=0; `tgt_ready`=1 the cycle after release.
- From `cur`=4'b0000, accept `tgt`=4'b1010 → one cycle of `s`=4'b1010, `r`=4'b0000. With the bank model connected, `done`=1 and `err`=0 three cycles after accept.
- Then accept `tgt`=4'b0110 → `s`=4'b0100, `r`=4'b1000. Lane 1 (1→1) and lane 0 (0→0) both give S=R=0.
- Force `q_fb`=4'b0000 during CHECK of `tgt`=4'b0001 → `err`=1 with `done`, `err_cnt` 0→1. With the macro undefined, `err`=0 and `err_cnt` stays 0.
- Back-to-back `tgt_valid` held high for 9 cycles → exactly 3 accepts, 3 `done` pulses, and `s&r`==0 in every cycle.
- Assert `rst`=0 in the DRIVE cycle → next cycle `s`=`r`=0, no `done`, `cur`=0; the first post-reset `tgt`=4'b1111 drives `s`=4'b1111.
